// File: rtl/dm_bus_responder_pkg.sv
// Shared encodings for the data-memory bus responder: access sizes, FSM states
// and the default memory depth.
package dm_bus_responder_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int DM_DEPTH_DEFAULT = 3072;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: write mask and merge for stores, lane extraction
// with zero/sign extension for loads, and the misalignment flag.
module dm_lane_unit
    import dm_bus_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        misalign
);

    logic [31:0] rep;
    logic [15:0] half;
    logic [7:0]  byt;

    always_comb begin
        be       = '0;
        rep      = '0;
        rd_data  = '0;
        misalign = 1'b0;
        wr_word  = old_word;
        half     = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        byt      = 8'(old_word >> {addr_lo, 3'b000});
        case (size)
            SIZE_WORD: begin
                be       = 4'hf;
                rep      = wdata;
                rd_data  = old_word;
                misalign = (addr_lo != 2'b00);
            end
            SIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                rep      = {2{wdata[15:0]}};
                rd_data  = {{16{sgn & half[15]}}, half};
                misalign = addr_lo[0];
            end
            SIZE_BYTE: begin
                be      = 4'b0001 << addr_lo;
                rep     = {4{wdata[7:0]}};
                rd_data = {{24{sgn & byt[7]}}, byt};
            end
            default: ;
        endcase
        // Unselected lanes keep the old word so partial stores are read-modify-write.
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = rep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_bus_responder.sv
// Valid/ready data-memory responder with programmable wait states.
// Define DM_WRITE_LOG_EN to print a log line for every successful store.
module dm_bus_responder
    import dm_bus_responder_pkg::*;
#(
    parameter int DEPTH       = DM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    dm_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic [1:0]       lat_size;
    logic             lat_signed;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;

    logic [31:0] mem [DEPTH];

    logic        in_range;
    logic [31:0] old_word;
    logic [3:0]  lane_be;
    logic [31:0] lane_wr;
    logic [31:0] lane_rd;
    logic        lane_misalign;
    logic        acc_err;
    logic        acc_now;
    logic        wr_en;

`ifdef DM_WRITE_LOG_EN
    logic [31:0] lat_pc;
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    assign in_range = (lat_addr[31:2] < 30'(DEPTH));
    assign old_word = in_range ? mem[lat_addr[AW+1:2]] : '0;
    assign acc_err  = lane_misalign | (lat_size == SIZE_RSVD) | ~in_range;
    // The access happens on the edge that leaves WAIT, after WAIT_CYCLES counted cycles.
    assign acc_now  = (state == ST_WAIT) && (cnt == CNT_W'(WAIT_CYCLES));
    assign wr_en    = acc_now && lat_we && !acc_err && (|lane_be);

    dm_lane_unit u_lane (
        .size     (lat_size),
        .sgn      (lat_signed),
        .addr_lo  (lat_addr[1:0]),
        .old_word (old_word),
        .wdata    (lat_wdata),
        .be       (lane_be),
        .wr_word  (lane_wr),
        .rd_data  (lane_rd),
        .misalign (lane_misalign)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_size   <= SIZE_WORD;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
`ifdef DM_WRITE_LOG_EN
            lat_pc     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
`ifdef DM_WRITE_LOG_EN
                        lat_pc     <= req_pc;
`endif
                        cnt        <= '0;
                        req_ready  <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (acc_now) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_we) ? '0 : lane_rd;
                        cnt       <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[lat_addr[AW+1:2]] <= lane_wr;
`ifdef DM_WRITE_LOG_EN
            $display("@%h: *%h <= %h", lat_pc, lat_addr, lane_wr);
`endif
        end
    end

endmodule

// File: tb/tb_dm_bus_responder.sv
// Scoreboard bench for dm_bus_responder: directed accesses push expected
// responses; a monitor compares them at each response handshake.
module tb_dm_bus_responder;

    localparam int WAITC = 1;
    localparam int DEPTH = 3072;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    dm_bus_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // Monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp: got err=%0b rdata=%h, none expected", rsp_err, rsp_rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL rsp: got err=%0b rdata=%h, want err=%0b rdata=%h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
        req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; req_pc = pc;
        req_valid = 1'b1;
    endtask

    task automatic scramble();
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
    endtask

    task automatic wait_accept(output logic acc);
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = req_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: got req_ready=0, want 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        logic acc, got;
        int lat;
        @(negedge clk);
        drive(we, sz, sg, addr, wd, 32'h0000_3008);
        exp_q.push_back({exp_err, exp_rd});
        wait_accept(acc);
        if (!acc) begin
            req_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        req_valid = 1'b0;
        scramble();
        lat = 1; got = rsp_valid;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = rsp_valid;
        end
        // lat counts edges from acceptance to rsp_valid rising
        check("latency", 32'(lat - 1), 32'(1 + WAITC));
        drain();
    endtask

    initial begin
        logic acc, got;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);

        issue(1, 2'b00, 0, 32'h10, 32'h1234_5678, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'h1234_5678, 0);
        issue(0, 2'b10, 1, 32'h13, 32'h0, 32'h0000_0012, 0);
        issue(1, 2'b10, 0, 32'h11, 32'hAAAA_AA80, 32'h0, 0);
        issue(0, 2'b10, 1, 32'h11, 32'h0, 32'hFFFF_FF80, 0);
        issue(0, 2'b10, 0, 32'h11, 32'h0, 32'h0000_0080, 0);
        issue(0, 2'b01, 0, 32'h10, 32'h0, 32'h0000_8078, 0);
        issue(0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFF_8078, 0);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_1234, 0);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'h1234_8078, 0);
        issue(1, 2'b01, 0, 32'h22, 32'h5555_ABCD, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h20, 32'h0, 32'hABCD_0000, 0);

        // error cases: loads and stores, memory must stay untouched
        issue(0, 2'b00, 0, 32'h02, 32'h0, 32'h0, 1);
        issue(0, 2'b01, 0, 32'h01, 32'h0, 32'h0, 1);
        issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
        issue(0, 2'b00, 0, DEPTH * 4, 32'h0, 32'h0, 1);
        issue(1, 2'b00, 0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1);
        issue(1, 2'b01, 0, 32'h11, 32'hFFFF_FFFF, 32'h0, 1);
        issue(1, 2'b11, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1);
        issue(1, 2'b00, 0, DEPTH * 4, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'h1234_8078, 0);
        issue(0, 2'b00, 0, 32'h00, 32'h0, 32'h0, 0);

        // last valid word
        issue(1, 2'b00, 0, DEPTH * 4 - 4, 32'hCAFE_F00D, 32'h0, 0);
        issue(0, 2'b00, 0, DEPTH * 4 - 4, 32'h0, 32'hCAFE_F00D, 0);

        // backpressure with a pending second request
        rsp_ready = 1'b0;
        @(negedge clk);
        drive(0, 2'b00, 0, 32'h10, 32'h0, 32'h0);
        exp_q.push_back({1'b0, 32'h1234_8078});
        wait_accept(acc);
        drive(0, 2'b10, 0, 32'h10, 32'h0, 32'h0);
        exp_q.push_back({1'b0, 32'h0000_0078});
        got = rsp_valid;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = rsp_valid;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1234_8078);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("bp_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        drain();

        // reset in the middle of a store
        @(negedge clk);
        drive(1, 2'b00, 0, 32'h20, 32'hDEAD_BEEF, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_in_wait", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("mid_req_ready", 32'(req_ready), 32'd1);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        issue(0, 2'b00, 0, 32'h20, 32'h0, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h10, 32'h0, 32'h0, 0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
